// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forward-select constants, memory-wait state enum, forward priority helper
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } mem_state_t;

    // Memory-stage result is younger than writeback, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_MEM;
        else if (hit_w)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle with master/slave views
interface hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E;
    logic [3:0]        WA3E, WA3M, WA3W;
    logic              RegWriteM, RegWriteW, MemToRegE;
    logic              PCSrcD, PCSrcE, PCSrcM, BranchTakenE;
    logic              MemReqM, MemReadyM;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW;
    logic              MemFault;
    logic [CNT_W-1:0]  StallCount, FlushCount;

    // Pipeline side: drives hazard sources, consumes control.
    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemToRegE,
        output PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemFault, StallCount, FlushCount
    );

    // Hazard unit side.
    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemToRegE,
        input  PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemFault, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// rtl/hazard_unit_sat_counter.sv - saturating up-counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    // Count qualified cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_count <= '0;
        else if (inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;
endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush control, memory-wait FSM and perf counters
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    hazard_unit_if.slave  bus
);
    localparam int WCNT_W = $clog2(MAX_WAIT);

    mem_state_t        r_state, w_next_state;
    logic [WCNT_W-1:0] r_wait_cnt, w_next_wait;

    logic              w_mem_wait;
    logic              w_ldr_stall, w_pc_pend;
    logic [ADDR_W-1:0] w_wa3e, w_wa3m, w_wa3w;
    logic [1:0]        w_fwd_a, w_fwd_b;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic              w_flush_d, w_flush_e, w_flush_w;
    logic [CNT_W-1:0]  w_stall_count, w_flush_count;

    assign w_wa3e = ADDR_W'(bus.WA3E);
    assign w_wa3m = ADDR_W'(bus.WA3M);
    assign w_wa3w = ADDR_W'(bus.WA3W);

    assign w_ldr_stall = bus.MemToRegE && ((bus.RA1D == w_wa3e) || (bus.RA2D == w_wa3e));
    assign w_pc_pend   = bus.PCSrcD || bus.PCSrcE || bus.PCSrcM;

    // Memory-wait state and wait-cycle counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Next-state logic; FAULT freezes the pipeline until reset.
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        w_mem_wait   = 1'b0;
        case (r_state)
            IDLE: begin
                w_mem_wait = bus.MemReqM && !bus.MemReadyM;
                if (w_mem_wait) begin
                    w_next_state = WAIT;
                    w_next_wait  = WCNT_W'(1);
                end
            end
            WAIT: begin
                w_mem_wait = bus.MemReqM && !bus.MemReadyM;
                if (bus.MemReadyM) begin
                    w_next_state = IDLE;
                    w_next_wait  = '0;
                end else if (r_wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
                    w_next_state = FAULT;
                end else begin
                    w_next_wait = r_wait_cnt + 1'b1;
                end
            end
            FAULT: begin
                w_mem_wait = 1'b1;
            end
            default: begin
                w_next_state = IDLE;
                w_next_wait  = '0;
            end
        endcase
    end

    // Forward selects and stall/flush; reset forces the quiescent pattern, memory wait beats everything else.
    always_comb begin
        w_fwd_a   = FWD_RF;
        w_fwd_b   = FWD_RF;
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (!RST_N) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_fwd_a = fwd_sel(bus.RegWriteM && (bus.RA1E == w_wa3m),
                              bus.RegWriteW && (bus.RA1E == w_wa3w));
            w_fwd_b = fwd_sel(bus.RegWriteM && (bus.RA2E == w_wa3m),
                              bus.RegWriteW && (bus.RA2E == w_wa3w));
            if (w_mem_wait) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_stall_m = 1'b1;
                w_flush_w = 1'b1;
            end else begin
                w_stall_f = w_ldr_stall || w_pc_pend;
                w_stall_d = w_ldr_stall;
                w_flush_d = w_pc_pend || bus.BranchTakenE;
                w_flush_e = w_ldr_stall || bus.BranchTakenE;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (w_stall_d),
        .count (w_stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (w_flush_e),
        .count (w_flush_count)
    );

    assign bus.ForwardAE  = w_fwd_a;
    assign bus.ForwardBE  = w_fwd_b;
    assign bus.StallF     = w_stall_f;
    assign bus.StallD     = w_stall_d;
    assign bus.StallE     = w_stall_e;
    assign bus.StallM     = w_stall_m;
    assign bus.FlushD     = w_flush_d;
    assign bus.FlushE     = w_flush_e;
    assign bus.FlushW     = w_flush_w;
    assign bus.MemFault   = (r_state == FAULT);
    assign bus.StallCount = w_stall_count;
    assign bus.FlushCount = w_flush_count;
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_unit_if #(.ADDR_W(5), .CNT_W(4)) bus ();

    hazard_unit #(.ADDR_W(5), .MAX_WAIT(4), .CNT_W(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.RA1D = '0; bus.RA2D = '0; bus.RA1E = '0; bus.RA2E = '0;
        bus.WA3E = '0; bus.WA3M = '0; bus.WA3W = '0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.MemToRegE = 1'b0;
        bus.PCSrcD = 1'b0; bus.PCSrcE = 1'b0; bus.PCSrcM = 1'b0;
        bus.BranchTakenE = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;

        // reset values, with a forwarding match present that must be masked
        bus.RA1E = 5'd3; bus.WA3M = 4'd3; bus.RegWriteM = 1'b1;
        #3;
        chk("rst_fwd_a", bus.ForwardAE, 2'b00);
        chk("rst_stall_f", bus.StallF, 1'b0);
        chk("rst_stall_d", bus.StallD, 1'b0);
        chk("rst_flush_d", bus.FlushD, 1'b1);
        chk("rst_flush_e", bus.FlushE, 1'b1);
        chk("rst_flush_w", bus.FlushW, 1'b0);
        chk("rst_fault", bus.MemFault, 1'b0);
        chk("rst_stall_cnt", bus.StallCount, 4'd0);
        chk("rst_flush_cnt", bus.FlushCount, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // forwarding priority
        to_drive();
        bus.WA3W = 4'd3; bus.RegWriteW = 1'b1;
        to_check();
        chk("fwd_mem_prio", bus.ForwardAE, 2'b10);
        chk("fwd_b_none", bus.ForwardBE, 2'b00);
        chk("idle_flush_d", bus.FlushD, 1'b0);
        chk("idle_flush_e", bus.FlushE, 1'b0);
        to_drive();
        bus.RegWriteM = 1'b0; bus.RA2E = 5'd3;
        to_check();
        chk("fwd_wb", bus.ForwardAE, 2'b01);
        chk("fwd_b_wb", bus.ForwardBE, 2'b01);
        to_drive();
        bus.RA1E = 5'h13;
        to_check();
        chk("fwd_zext", bus.ForwardAE, 2'b00);
        to_drive();
        bus.RegWriteW = 1'b0; bus.RA1E = '0; bus.RA2E = '0;

        // load-use stall lasts one cycle
        bus.MemToRegE = 1'b1; bus.WA3E = 4'd5; bus.RA2D = 5'd5;
        to_check();
        chk("ldr_stall_f", bus.StallF, 1'b1);
        chk("ldr_stall_d", bus.StallD, 1'b1);
        chk("ldr_flush_e", bus.FlushE, 1'b1);
        chk("ldr_flush_d", bus.FlushD, 1'b0);
        chk("ldr_stall_e", bus.StallE, 1'b0);
        to_drive();
        bus.MemToRegE = 1'b0;
        to_check();
        chk("ldr_done_stall_d", bus.StallD, 1'b0);
        chk("ldr_stall_cnt", bus.StallCount, 4'd1);
        chk("ldr_flush_cnt", bus.FlushCount, 4'd1);

        // memory wait for 3 cycles with a coincident taken branch
        to_drive();
        bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; bus.BranchTakenE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_check();
            chk("mw_stall_f", bus.StallF, 1'b1);
            chk("mw_stall_e", bus.StallE, 1'b1);
            chk("mw_stall_m", bus.StallM, 1'b1);
            chk("mw_flush_w", bus.FlushW, 1'b1);
            chk("mw_flush_d", bus.FlushD, 1'b0);
            chk("mw_flush_e", bus.FlushE, 1'b0);
            to_drive();
        end
        bus.MemReadyM = 1'b1;
        to_check();
        chk("mw_rdy_stall_e", bus.StallE, 1'b0);
        chk("mw_rdy_flush_w", bus.FlushW, 1'b0);
        chk("mw_rdy_flush_d", bus.FlushD, 1'b1);
        chk("mw_rdy_flush_e", bus.FlushE, 1'b1);
        to_drive();
        bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0; bus.BranchTakenE = 1'b0;
        to_check();
        chk("mw_fault", bus.MemFault, 1'b0);
        chk("mw_idle_stall_m", bus.StallM, 1'b0);
        chk("mw_stall_cnt", bus.StallCount, 4'd4);
        chk("mw_flush_cnt", bus.FlushCount, 4'd2);

        // timeout after MAX_WAIT wait cycles, then sticky
        to_drive();
        bus.MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_check();
            chk("to_pre_fault", bus.MemFault, 1'b0);
            to_drive();
        end
        bus.MemReqM = 1'b0;
        to_check();
        chk("to_fault", bus.MemFault, 1'b1);
        chk("to_frozen_stall_f", bus.StallF, 1'b1);
        chk("to_frozen_flush_w", bus.FlushW, 1'b1);
        to_drive();
        to_check();
        chk("to_fault_sticky", bus.MemFault, 1'b1);

        // asynchronous reset mid-cycle clears the fault
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_fault", bus.MemFault, 1'b0);
        chk("arst_stall_f", bus.StallF, 1'b0);
        chk("arst_flush_d", bus.FlushD, 1'b1);
        chk("arst_stall_cnt", bus.StallCount, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // branch without memory wait, then branch with load-use
        to_drive();
        bus.BranchTakenE = 1'b1;
        to_check();
        chk("br_flush_d", bus.FlushD, 1'b1);
        chk("br_flush_e", bus.FlushE, 1'b1);
        chk("br_stall_d", bus.StallD, 1'b0);
        to_drive();
        bus.MemToRegE = 1'b1; bus.WA3E = 4'd5; bus.RA1D = 5'd5; bus.RA2D = '0;
        to_check();
        chk("brldr_flush_e", bus.FlushE, 1'b1);
        chk("brldr_stall_d", bus.StallD, 1'b1);
        chk("brldr_flush_d", bus.FlushD, 1'b1);
        to_drive();
        bus.BranchTakenE = 1'b0;
        to_check();
        chk("brldr_stall_cnt", bus.StallCount, 4'd1);
        chk("brldr_flush_cnt", bus.FlushCount, 4'd2);

        // saturation with the load-use stall held
        repeat (13) to_drive();
        to_check();
        chk("sat_pre_stall_cnt", bus.StallCount, 4'd14);
        repeat (7) to_drive();
        to_check();
        chk("sat_stall_cnt", bus.StallCount, 4'd15);
        chk("sat_flush_cnt", bus.FlushCount, 4'd15);
        bus.MemToRegE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
